// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
//   Shared definitions for the two-requester seven-segment display arbiter.
//   - FSM state encoding.  The OWN0/OWN1 codes equal the grant vector they
//     produce, so the registered state is also the registered grant.
//   - Active-low segment patterns for hex digits 0..F, bit order a..g = 6..0.
//   - Blank patterns for the anode and segment outputs.
//   - Small helpers for anode selection and leading-zero blanking.
// -----------------------------------------------------------------------------
package disp_pkg;

  // Arbitration FSM states.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

  // Everything off: all anodes deselected, all segments dark.
  localparam logic [3:0] AN_BLANK  = 4'b1111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Hex digit segment patterns, active-low, a..g in bits 6..0.
  localparam logic [6:0] SEG_HEX_0 = 7'b0000001;
  localparam logic [6:0] SEG_HEX_1 = 7'b1001111;
  localparam logic [6:0] SEG_HEX_2 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_3 = 7'b0000110;
  localparam logic [6:0] SEG_HEX_4 = 7'b1001100;
  localparam logic [6:0] SEG_HEX_5 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_6 = 7'b0100000;
  localparam logic [6:0] SEG_HEX_7 = 7'b0001111;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0000100;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b1100000;
  localparam logic [6:0] SEG_HEX_C = 7'b0110001;
  localparam logic [6:0] SEG_HEX_D = 7'b1000010;
  localparam logic [6:0] SEG_HEX_E = 7'b0110000;
  localparam logic [6:0] SEG_HEX_F = 7'b0111000;

  // One displayed digit: anode enables plus segment pattern.
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } disp_t;

  // Active-low one-hot anode enable for digit k.
  function automatic logic [3:0] an_for_digit(input logic [1:0] k);
    return ~(4'b0001 << k);
  endfunction

  // Leading-zero blanking: a digit is dark when it and every more
  // significant nibble are zero.  Digit 0 always shows, so a value of
  // zero still displays a single "0".
  function automatic logic digit_blanked(input logic [15:0] v,
                                         input logic [1:0]  k);
    logic blank;
    case (k)
      2'd3:    blank = (v[15:12] == 4'h0);
      2'd2:    blank = (v[15:8]  == 8'h00);
      2'd1:    blank = (v[15:4]  == 12'h000);
      default: blank = 1'b0;
    endcase
    return blank;
  endfunction

  // Nibble k of a four-digit hex value, digit 0 = bits 3:0.
  function automatic logic [3:0] nibble_of(input logic [15:0] v,
                                           input logic [1:0]  k);
    logic [3:0] n;
    case (k)
      2'd0:    n = v[3:0];
      2'd1:    n = v[7:4];
      2'd2:    n = v[11:8];
      default: n = v[15:12];
    endcase
    return n;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
//   Purely combinational hex-digit to seven-segment decoder.
//   Ports:
//     hex  in  4  digit value 0..F
//     seg  out 7  active-low segments, a..g in bits 6..0
// -----------------------------------------------------------------------------
module hex_to_seg7
  import disp_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/disp_arbiter.sv
// -----------------------------------------------------------------------------
// disp_arbiter
//   Shares one four-digit multiplexed seven-segment display between two
//   requesters.  A free-running scan divider produces a one-cycle tick every
//   SCAN_DIV clocks; each tick advances the displayed digit and ages the
//   current owner's hold count.  An owner may be preempted by the other
//   requester only on a tick once it has held the display for HOLD ticks;
//   a voluntary release hands over immediately.
//
//   Parameters:
//     SCAN_DIV  clk cycles per scan tick (4 .. 2^20)
//     HOLD      scan ticks of ownership before preemption (1 .. 255)
//   Ports:
//     clk   in   1   clock, rising edge
//     rst   in   1   asynchronous active-high reset
//     req   in   2   req[i] = requester i wants the display
//     val0  in  16   requester 0 value, four hex digits, digit 0 = bits 3:0
//     val1  in  16   requester 1 value, same layout
//     gnt   out  2   registered grant, one-hot or zero
//     an    out  4   registered anode enables, active-low
//     seg   out  7   registered segments, active-low, a..g = bits 6..0
// -----------------------------------------------------------------------------
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 200000,
  parameter int HOLD     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  output logic [1:0]  gnt,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int              CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [7:0]       HOLD_SAT = 8'(HOLD);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       dig_q,   dig_d;
  logic [1:0]       state_q, state_d;
  logic [7:0]       hold_q,  hold_d;
  logic             last_q,  last_d;
  logic [3:0]       an_q,    an_d;
  logic [6:0]       seg_q,   seg_d;

  logic             tick;
  logic             hold_met;
  logic [15:0]      owner_val;
  logic [3:0]       owner_nib;
  logic [6:0]       owner_seg;
  disp_t            disp_d;

  // ---------------------------------------------------------------------------
  // Scan divider and digit index
  // ---------------------------------------------------------------------------
  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    dig_d = dig_q;
    if (tick) begin
      cnt_d = '0;
      dig_d = dig_q + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration FSM
  // ---------------------------------------------------------------------------
  assign hold_met = (hold_q >= HOLD_SAT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        case (req)
          2'b01:   state_d = ST_OWN0;
          2'b10:   state_d = ST_OWN1;
          // Contention from idle goes to whoever did not own it last.
          2'b11:   state_d = last_q ? ST_OWN0 : ST_OWN1;
          default: state_d = ST_IDLE;
        endcase
      end
      ST_OWN0: begin
        // Release is checked first so it wins over a same-cycle preemption.
        if (!req[0]) begin
          state_d = req[1] ? ST_OWN1 : ST_IDLE;
        end else if (tick && req[1] && hold_met) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN1: begin
        if (!req[1]) begin
          state_d = req[0] ? ST_OWN0 : ST_IDLE;
        end else if (tick && req[0] && hold_met) begin
          state_d = ST_OWN0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Last owner only changes when somebody is granted; IDLE keeps the history.
  always_comb begin
    last_d = last_q;
    if (state_d == ST_OWN0) begin
      last_d = 1'b0;
    end else if (state_d == ST_OWN1) begin
      last_d = 1'b1;
    end
  end

  // Hold counter: restarts on any grant change (including to IDLE) and
  // ages on ticks while owned, saturating so it never wraps back below HOLD.
  always_comb begin
    hold_d = hold_q;
    if (state_d != state_q) begin
      hold_d = '0;
    end else if ((state_q != ST_IDLE) && tick && !hold_met) begin
      hold_d = hold_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Display path: current digit of the current owner's live value
  // ---------------------------------------------------------------------------
  assign owner_val = (state_q == ST_OWN1) ? val1 : val0;
  assign owner_nib = nibble_of(owner_val, dig_q);

  hex_to_seg7 u_hex_to_seg7 (
    .hex (owner_nib),
    .seg (owner_seg)
  );

  always_comb begin
    disp_d.an  = AN_BLANK;
    disp_d.seg = SEG_BLANK;
    if ((state_q != ST_IDLE) && !digit_blanked(owner_val, dig_q)) begin
      disp_d.an  = an_for_digit(dig_q);
      disp_d.seg = owner_seg;
    end
    an_d  = disp_d.an;
    seg_d = disp_d.seg;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      dig_q   <= 2'd0;
      state_q <= ST_IDLE;
      hold_q  <= '0;
      last_q  <= 1'b1;
      an_q    <= AN_BLANK;
      seg_q   <= SEG_BLANK;
    end else begin
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  // The OWN state codes are the grant vectors themselves.
  assign gnt = state_q;
  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_disp_arbiter
//   Directed bench for disp_arbiter with SCAN_DIV=4, HOLD=2.  The driver
//   queues {gnt, an, seg} expectations tagged with the cycle they apply to;
//   a monitor process compares them one step after each rising edge.
// -----------------------------------------------------------------------------
module tb_disp_arbiter;

  localparam int SCAN_DIV = 4;
  localparam int HOLD     = 2;

  // Segment patterns written out independently of the design package.
  localparam logic [6:0] S_0  = 7'b0000001;
  localparam logic [6:0] S_2  = 7'b0010010;
  localparam logic [6:0] S_3  = 7'b0000110;
  localparam logic [6:0] S_4  = 7'b1001100;
  localparam logic [6:0] S_5  = 7'b0100100;
  localparam logic [6:0] S_A  = 7'b0001000;
  localparam logic [6:0] S_D  = 7'b1000010;
  localparam logic [6:0] S_BL = 7'b1111111;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] val0;
  logic [15:0] val1;
  logic [1:0]  gnt;
  logic [3:0]  an;
  logic [6:0]  seg;

  int cyc;
  int n_cmp;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  disp_arbiter #(
    .SCAN_DIV (SCAN_DIV),
    .HOLD     (HOLD)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .val0 (val0),
    .val1 (val1),
    .gnt  (gnt),
    .an   (an),
    .seg  (seg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [12:0] exp_q[$];
  int          exp_cyc_q[$];
  string       exp_tag_q[$];

  task automatic expect_at(input int c, input string tag, input logic [1:0] g,
                           input logic [3:0] a, input logic [6:0] s);
    exp_q.push_back({g, a, s});
    exp_cyc_q.push_back(c);
    exp_tag_q.push_back(tag);
  endtask

  task automatic check_now(input string tag, input logic [1:0] g,
                           input logic [3:0] a, input logic [6:0] s);
    n_cmp++;
    if (gnt !== g || an !== a || seg !== s) begin
      n_bad++;
      $display("FAIL %s: gnt/an/seg got %b/%b/%b expected %b/%b/%b",
               tag, gnt, an, seg, g, a, s);
    end
  endtask

  initial begin : monitor
    logic [12:0] e;
    int          c;
    string       t;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        t = exp_tag_q.pop_front();
        if (c < cyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s: check slot missed, due cycle %0d now %0d", t, c, cyc);
        end else begin
          check_now(t, e[12:11], e[10:7], e[6:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations still pending, expected 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
      exp_tag_q.delete();
    end
  endtask

  // Returns the cycle number at whose falling edge reset was released.
  task automatic reset_release(output int r);
    @(negedge clk);
    rst = 1'b1;
    req = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    r   = cyc;
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin : driver
    int r;
    cyc   = 0;
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    req   = 2'b00;
    val0  = 16'h0000;
    val1  = 16'h0000;
    repeat (3) @(negedge clk);
    check_now("reset_state", 2'b00, 4'b1111, S_BL);

    // Single requester 0, value 0x0005: only digit 0 lights.
    reset_release(r);
    req  = 2'b01;
    val0 = 16'h0005;
    expect_at(r + 1,  "s1_grant",      2'b01, 4'b1111, S_BL);
    expect_at(r + 2,  "s1_dig0",       2'b01, 4'b1110, S_5);
    expect_at(r + 4,  "s1_dig0_end",   2'b01, 4'b1110, S_5);
    expect_at(r + 5,  "s1_dig1_blank", 2'b01, 4'b1111, S_BL);
    expect_at(r + 9,  "s1_dig2_blank", 2'b01, 4'b1111, S_BL);
    expect_at(r + 13, "s1_dig3_blank", 2'b01, 4'b1111, S_BL);
    expect_at(r + 17, "s1_dig0_wrap",  2'b01, 4'b1110, S_5);
    drain();

    // Both request from idle: 0 wins, holds two ticks, preempted on third.
    reset_release(r);
    req  = 2'b11;
    val0 = 16'h1234;
    val1 = 16'h0A30;
    expect_at(r + 1,  "s2_grant0",     2'b01, 4'b1111, S_BL);
    expect_at(r + 2,  "s2_v0_dig0",    2'b01, 4'b1110, S_4);
    expect_at(r + 5,  "s2_v0_dig1",    2'b01, 4'b1101, S_3);
    expect_at(r + 8,  "s2_hold_tick2", 2'b01, 4'b1101, S_3);
    expect_at(r + 11, "s2_pre_switch", 2'b01, 4'b1011, S_2);
    expect_at(r + 12, "s2_preempt",    2'b10, 4'b1011, S_2);
    expect_at(r + 13, "s2_v1_dig3_bl", 2'b10, 4'b1111, S_BL);
    expect_at(r + 17, "s2_v1_dig0",    2'b10, 4'b1110, S_0);
    expect_at(r + 21, "s2_v1_dig1",    2'b10, 4'b1101, S_3);
    expect_at(r + 25, "s2_v1_dig2",    2'b10, 4'b1011, S_A);
    wait_cyc(r + 14);
    req = 2'b10;
    drain();

    // Owner 0 releases with 1 waiting: hand over without a tick, then idle.
    reset_release(r);
    req  = 2'b01;
    val0 = 16'h00C0;
    val1 = 16'h000D;
    expect_at(r + 1, "s3_grant0",   2'b01, 4'b1111, S_BL);
    expect_at(r + 2, "s3_v0_dig0",  2'b01, 4'b1110, S_0);
    expect_at(r + 3, "s3_release",  2'b10, 4'b1110, S_0);
    expect_at(r + 4, "s3_idle",     2'b00, 4'b1110, S_D);
    expect_at(r + 5, "s3_idle_blk", 2'b00, 4'b1111, S_BL);
    wait_cyc(r + 2);
    req = 2'b10;
    wait_cyc(r + 3);
    req = 2'b00;
    drain();

    // Reset mid-ownership at digit 2: outputs clear without a clock edge,
    // and the last-owner history returns to 1 so requester 0 wins again.
    reset_release(r);
    req  = 2'b01;
    val0 = 16'h1234;
    expect_at(r + 10, "s4_dig2", 2'b01, 4'b1011, S_2);
    wait_cyc(r + 10);
    drain();
    #2;
    rst = 1'b1;
    #1;
    check_now("s4_async_reset", 2'b00, 4'b1111, S_BL);
    req = 2'b11;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r   = cyc;
    expect_at(r + 1, "s4_regrant0", 2'b01, 4'b1111, S_BL);
    expect_at(r + 2, "s4_v0_dig0",  2'b01, 4'b1110, S_4);
    drain();

    summary();
    $finish;
  end

  initial begin : watchdog
    #100000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    summary();
    $finish;
  end

endmodule
